// File: rtl/note_sequencer_pkg.sv
// Shared types for the note sequencer: FSM states and table entry sizing.
package note_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int TEMPO_BITS = 16;

    function automatic int entry_width(input int phasesize);
        return phasesize + 1;
    endfunction

endpackage

// File: rtl/note_sequencer_lrclk_tick_sync.sv
// lrclk_tick_sync: two-flop synchroniser plus rising-edge detect.
// tick is a registered one-clk pulse, three clk edges after an lrclk rise.
module lrclk_tick_sync (
    input  logic clk,
    input  logic reset,
    input  logic lrclk,
    output logic tick
);

    logic [2:0] sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh   <= '0;
            tick <= 1'b0;
        end else begin
            sh   <= {sh[1:0], lrclk};
            tick <= sh[1] & ~sh[2];
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer with linear attack/release envelope driving one sine voice.
// Table entries are {gate, freq}; steps advance every `tempo` lrclk samples.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int PHASESIZE   = 16,
    parameter int STEPS       = 8,
    parameter int ENVBITS     = 8,
    parameter int ATTACK_INC  = 8,
    parameter int RELEASE_DEC = 2,
    localparam int AW = $clog2(STEPS),
    localparam int EW = entry_width(PHASESIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lrclk,
    input  logic                  run,
    input  logic [TEMPO_BITS-1:0] tempo,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [PHASESIZE-1:0]  wr_freq,
    input  logic                  wr_gate,
    output logic [PHASESIZE-1:0]  freq,
    output logic                  voice_en,
    output logic [ENVBITS-1:0]    env,
    output logic [AW-1:0]         step_idx,
    output logic                  step_pulse,
    output logic                  busy
);

    localparam logic [ENVBITS:0] ATK = (ENVBITS + 1)'(ATTACK_INC);
    localparam logic [ENVBITS:0] REL = (ENVBITS + 1)'(RELEASE_DEC);

    logic [EW-1:0]         table_q [STEPS];
    logic                  tick;
    state_t                state;
    logic [TEMPO_BITS-1:0] cnt;
    logic [TEMPO_BITS-1:0] cnt_max;
    logic                  gate_q;
    logic                  load_q;
    logic                  restart;
    logic [ENVBITS:0]      env_up;
    logic [ENVBITS:0]      env_dn;
    logic [ENVBITS-1:0]    env_nx;

    lrclk_tick_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .lrclk (lrclk),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STEPS; i++) table_q[i] <= '0;
        end else if (wr_en) begin
            table_q[wr_addr] <= {wr_gate, wr_freq};
        end
    end

    assign cnt_max = (tempo == '0) ? '0 : tempo - 1'b1;
    assign restart = run && (state != PLAY);
    assign busy    = (state != IDLE);

    // Saturation is taken from the carry/borrow of the widened sum.
    assign env_up = {1'b0, env} + ATK;
    assign env_dn = {1'b0, env} - REL;
    assign env_nx = gate_q
        ? (env_up[ENVBITS] ? '1 : env_up[ENVBITS-1:0])
        : (env_dn[ENVBITS] ? '0 : env_dn[ENVBITS-1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            gate_q     <= 1'b0;
            load_q     <= 1'b0;
            freq       <= '0;
            voice_en   <= 1'b0;
            env        <= '0;
            step_idx   <= '0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            if (restart) begin
                state      <= PLAY;
                voice_en   <= 1'b1;
                freq       <= table_q[0][PHASESIZE-1:0];
                gate_q     <= table_q[0][PHASESIZE];
                step_idx   <= '0;
                step_pulse <= 1'b1;
                cnt        <= '0;
                load_q     <= 1'b0;
            end else begin
                unique case (state)
                    PLAY: begin
                        if (!run) begin
                            state  <= RELEASE;
                            gate_q <= 1'b0;
                            load_q <= 1'b0;
                        end else begin
                            if (load_q) begin
                                {gate_q, freq} <= table_q[step_idx];
                                step_pulse     <= 1'b1;
                                load_q         <= 1'b0;
                            end
                            if (tick) begin
                                env <= env_nx;
                                if (cnt == cnt_max) begin
                                    cnt      <= '0;
                                    step_idx <= step_idx + AW'(1);
                                    load_q   <= 1'b1;
                                end else begin
                                    cnt <= cnt + 1'b1;
                                end
                            end
                        end
                    end
                    RELEASE: begin
                        if (env == '0) begin
                            state    <= IDLE;
                            voice_en <= 1'b0;
                            step_idx <= '0;
                            freq     <= '0;
                        end else if (tick) begin
                            env <= env_nx;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        voice_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed + randomized bench for note_sequencer against a tick-level model.
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lrclk = 1'b0;
    logic        run = 1'b0;
    logic [15:0] tempo = 16'd4;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [15:0] wr_freq = '0;
    logic        wr_gate = 1'b0;
    logic [15:0] freq;
    logic        voice_en;
    logic [7:0]  env;
    logic [1:0]  step_idx;
    logic        step_pulse;
    logic        busy;

    note_sequencer #(.STEPS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .lrclk      (lrclk),
        .run        (run),
        .tempo      (tempo),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_freq    (wr_freq),
        .wr_gate    (wr_gate),
        .freq       (freq),
        .voice_en   (voice_en),
        .env        (env),
        .step_idx   (step_idx),
        .step_pulse (step_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int mon_pulses = 0;

    always @(posedge clk) begin
        if (reset) mon_pulses <= 0;
        else if (step_pulse) mon_pulses <= mon_pulses + 1;
    end

    // Reference model: state 0=idle 1=playing 2=releasing
    int m_st = 0, m_idx = 0, m_cnt = 0, m_env = 0;
    int m_freq = 0, m_gate = 0, m_pulses = 0, m_run = 0;
    int mf [4];
    int mg [4];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".freq"}, 32'(freq), m_freq);
        chk({tag, ".env"}, 32'(env), m_env);
        chk({tag, ".idx"}, 32'(step_idx), m_idx);
        chk({tag, ".busy"}, 32'(busy), 32'(m_st != 0));
        chk({tag, ".voice"}, 32'(voice_en), 32'(m_st != 0));
    endtask

    task automatic m_idle();
        m_st = 0; m_idx = 0; m_freq = 0; m_gate = 0;
    endtask

    task automatic m_start();
        m_st = 1; m_idx = 0; m_cnt = 0;
        m_freq = mf[0]; m_gate = mg[0];
        m_pulses++;
    endtask

    task automatic m_tick();
        int lim;
        if (m_st == 1) begin
            m_env = m_gate != 0 ? ((m_env + 8 > 255) ? 255 : m_env + 8)
                                : ((m_env < 2) ? 0 : m_env - 2);
            lim = (tempo == 0) ? 1 : int'(tempo);
            if (m_cnt == lim - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
                m_freq = mf[m_idx];
                m_gate = mg[m_idx];
                m_pulses++;
            end else begin
                m_cnt++;
            end
        end else if (m_st == 2) begin
            m_env = (m_env < 2) ? 0 : m_env - 2;
            if (m_env == 0) m_idle();
        end
    endtask

    task automatic set_run(input int r);
        @(negedge clk);
        run = r[0];
        m_run = r;
        if (r != 0 && m_st != 1) m_start();
        else if (r == 0 && m_st == 1) begin
            m_st = 2; m_gate = 0;
            if (m_env == 0) m_idle();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic write_entry(input int a, input int f, input int g);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a[1:0]; wr_freq = f[15:0]; wr_gate = g[0];
        @(negedge clk);
        wr_en = 1'b0;
        mf[a] = f; mg[a] = g;
    endtask

    // One lrclk period; optionally write entry `wa` in the clk its load happens
    task automatic do_tick(input int wr, input int wa, input int wf);
        logic [1:0] idx0;
        bit done;
        done = 0;
        idx0 = step_idx;
        @(negedge clk);
        lrclk = 1'b1;
        m_tick();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (wr != 0 && !done && step_idx != idx0) begin
                wr_en = 1'b1; wr_addr = wa[1:0]; wr_freq = wf[15:0];
                wr_gate = 1'b1;
                @(negedge clk);
                wr_en = 1'b0;
                done = 1;
            end
        end
        if (wr != 0) begin
            chk("collide_seen", 32'(done), 32'd1);
            mf[wa] = wf; mg[wa] = 1;
        end
        lrclk = 1'b0;
        repeat (32) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin mf[i] = 0; mg[i] = 0; end

        repeat (3) @(negedge clk);
        chk("rst.freq", 32'(freq), 0);
        chk("rst.env", 32'(env), 0);
        chk("rst.idx", 32'(step_idx), 0);
        chk("rst.pulse", 32'(step_pulse), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.voice", 32'(voice_en), 0);
        reset = 1'b0;

        for (int t = 0; t < 100; t++) begin
            do_tick(0, 0, 0);
            check_all("idle");
        end

        write_entry(0, 300, 1);
        write_entry(1, 1201, 1);
        write_entry(2, 2403, 1);
        write_entry(3, 9612, 1);
        tempo = 16'd4;
        set_run(1);
        check_all("start");
        chk("start.f0", 32'(freq), 300);
        for (int t = 1; t <= 32; t++) begin
            do_tick(0, 0, 0);
            check_all("attack");
            if (t == 31) chk("env248", 32'(env), 248);
        end
        chk("env_sat", 32'(env), 255);
        chk("pulses_a", 32'(mon_pulses), m_pulses);

        repeat (3) do_tick(0, 0, 0);
        do_tick(1, 1, 5555);
        check_all("collide");
        chk("collide_old", 32'(freq), 1201);
        repeat (16) do_tick(0, 0, 0);
        check_all("collide2");
        chk("collide_new", 32'(freq), 5555);

        set_run(0);
        check_all("rel0");
        for (int t = 0; t < 128; t++) begin
            do_tick(0, 0, 0);
            check_all("release");
        end
        chk("rel.busy", 32'(busy), 0);
        chk("rel.idx", 32'(step_idx), 0);
        chk("rel.env", 32'(env), 0);

        set_run(1);
        for (int t = 0; t < 200; t++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 2)
                write_entry($urandom_range(0, 3), $urandom_range(0, 65535),
                            ($urandom_range(0, 3) != 0) ? 1 : 0);
            else if (r < 4 && m_cnt == 0)
                tempo = 16'($urandom_range(0, 5));
            else if (r == 4)
                set_run(m_run == 0 ? 1 : 0);
            do_tick(0, 0, 0);
            check_all("rand");
        end
        chk("pulses_r", 32'(mon_pulses), m_pulses);

        set_run(0);
        for (int t = 0; t < 140 && m_st != 0; t++) do_tick(0, 0, 0);
        check_all("drain");
        tempo = 16'd0;
        set_run(1);
        for (int t = 0; t < 6; t++) begin
            do_tick(0, 0, 0);
            check_all("tempo0");
        end

        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst.freq", 32'(freq), 0);
        chk("arst.env", 32'(env), 0);
        chk("arst.busy", 32'(busy), 0);
        chk("arst.voice", 32'(voice_en), 0);
        chk("arst.idx", 32'(step_idx), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
